// File: rtl/interrupt_ctrl_pkg.sv
// Shared Game Boy interrupt definitions: source bit indices, dispatch vectors
// and the CPU-visible register addresses of the interrupt block.
package interrupt_ctrl_pkg;

  localparam int unsigned NUM_IRQ = 5;

  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_STAT   = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;

  localparam logic [7:0] VEC_NONE   = 8'h00;
  localparam logic [7:0] VEC_VBLANK = 8'h40;
  localparam logic [7:0] VEC_STAT   = 8'h48;
  localparam logic [7:0] VEC_TIMER  = 8'h50;
  localparam logic [7:0] VEC_SERIAL = 8'h58;
  localparam logic [7:0] VEC_JOYPAD = 8'h60;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CPU-side bus of the interrupt controller: IF/IE register access plus the
// interrupt request / dispatch handshake.
interface interrupt_ctrl_if;

  logic       cpu_sel_if;
  logic       cpu_sel_ie;
  logic       cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       irq_n;
  logic       irq_ack;
  logic [7:0] irq_vector;

  modport master (
    output cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, irq_ack,
    input  cpu_do, irq_n, irq_vector
  );

  modport slave (
    input  cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, irq_ack,
    output cpu_do, irq_n, irq_vector
  );

endinterface

// File: rtl/interrupt_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: lowest pending bit wins, producing a one-hot grant
// and the matching dispatch vector (0x00 when nothing is pending).
module irq_prio_enc
  import interrupt_ctrl_pkg::*;
(
  input  logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] grant,
  output logic [7:0]         vector
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    grant  = '0;
    vector = VEC_NONE;
    if (pending[INT_VBLANK]) begin
      grant[INT_VBLANK] = 1'b1;
      vector            = VEC_VBLANK;
    end else if (pending[INT_STAT]) begin
      grant[INT_STAT] = 1'b1;
      vector          = VEC_STAT;
    end else if (pending[INT_TIMER]) begin
      grant[INT_TIMER] = 1'b1;
      vector           = VEC_TIMER;
    end else if (pending[INT_SERIAL]) begin
      grant[INT_SERIAL] = 1'b1;
      vector            = VEC_SERIAL;
    end else if (pending[INT_JOYPAD]) begin
      grant[INT_JOYPAD] = 1'b1;
      vector            = VEC_JOYPAD;
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Game Boy interrupt controller: edge-detected request latching into IF,
// IE enable mask, priority vector generation and dispatch acknowledge.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [NUM_IRQ-1:0] irq_src,
  interrupt_ctrl_if.slave    bus
);

  logic [NUM_IRQ-1:0] if_r;
  logic [NUM_IRQ-1:0] if_nxt;
  logic [NUM_IRQ-1:0] src_r;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] grant;
  logic [NUM_IRQ-1:0] edge_set;
  logic [7:0]         ie_r;
  logic [7:0]         vector;
  logic               armed_r;

  assign pending = if_r & ie_r[NUM_IRQ-1:0];

  irq_prio_enc u_prio_enc (
    .pending (pending),
    .grant   (grant),
    .vector  (vector)
  );

  // armed_r stays low until the first ce after reset so a source already high
  // at reset release is sampled into src_r rather than seen as a fresh edge.
  assign edge_set = irq_src & ~src_r & {NUM_IRQ{armed_r}};

  // Same-ce ordering per bit: CPU write, then ack clear, then edge set.
  // grant comes from the pre-write IF/IE, so a coincident IE write cannot
  // redirect the acknowledge.
  always_comb begin
    if_nxt = if_r;
    if (bus.cpu_wr && bus.cpu_sel_if) if_nxt = bus.cpu_di[NUM_IRQ-1:0];
    if (bus.irq_ack)                  if_nxt = if_nxt & ~grant;
    if_nxt = if_nxt | edge_set;
  end

  // NOTE: state registers use non-blocking assignments and are all cleared by
  // the asynchronous reset, so an ack in flight leaves nothing behind.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      if_r    <= '0;
      ie_r    <= '0;
      src_r   <= '0;
      armed_r <= 1'b0;
    end else if (ce) begin
      if_r    <= if_nxt;
      src_r   <= irq_src;
      armed_r <= 1'b1;
      if (bus.cpu_wr && bus.cpu_sel_ie) ie_r <= bus.cpu_di;
    end
  end

  always_comb begin
    bus.cpu_do = 8'hFF;
    if (bus.cpu_sel_if)      bus.cpu_do = {3'b111, if_r};
    else if (bus.cpu_sel_ie) bus.cpu_do = ie_r;
  end

  assign bus.irq_n      = ~|pending;
  assign bus.irq_vector = vector;

endmodule
